mdu_ctrl: RTL and testbench

- Multiply/divide unit controller for the 5-stage MIPS pipeline.
- Sits in the E stage. Accepts mult/multu/div/divu/mthi/mtlo from E, and owns the HI/LO registers.
- Models the multi-cycle latency with a busy counter and drives the D-stage stall request for multiply/divide-class instructions.
- The arithmetic is computed in one step and committed to HI/LO when the latency count expires.

---
 rtl/mdu_ctrl_pkg.sv | 27 ++
 rtl/mdu_calc.sv | 60 ++++++
 rtl/mdu_ctrl.sv | 99 +++++++++
 tb/tb_mdu_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared op and state encodings for the multiply/divide unit
package mdu_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_t;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   function automatic logic is_md_arith(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_md_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - single-step product/quotient datapath feeding the HI/LO shadow registers
module mdu_calc
   import mdu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_res,
   output logic [WIDTH-1:0] lo_res,
   output logic             div_zero
);

   logic signed [2*WIDTH-1:0] prod_s;
   logic        [2*WIDTH-1:0] prod_u;
   logic                      div_signed;
   logic                      neg_a;
   logic                      neg_b;
   logic        [WIDTH-1:0]   mag_a;
   logic        [WIDTH-1:0]   mag_b;
   logic        [WIDTH-1:0]   divisor;
   logic        [WIDTH-1:0]   quo;
   logic        [WIDTH-1:0]   rem;

   assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   // Divide on magnitudes so the most-negative dividend by -1 wraps to itself.
   assign div_signed = (op == MD_DIV);
   assign neg_a      = div_signed && a[WIDTH-1];
   assign neg_b      = div_signed && b[WIDTH-1];
   assign mag_a      = neg_a ? (~a + 1'b1) : a;
   assign mag_b      = neg_b ? (~b + 1'b1) : b;
   assign divisor    = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
   assign quo        = mag_a / divisor;
   assign rem        = mag_a % divisor;
   assign div_zero   = is_md_div(op) && (b == '0);

   always_comb begin
      hi_res = '0;
      lo_res = '0;
      case (op)
         MD_MULT: begin
            hi_res = prod_s[2*WIDTH-1:WIDTH];
            lo_res = prod_s[WIDTH-1:0];
         end
         MD_MULTU: begin
            hi_res = prod_u[2*WIDTH-1:WIDTH];
            lo_res = prod_u[WIDTH-1:0];
         end
         MD_DIV, MD_DIVU: begin
            lo_res = (neg_a ^ neg_b) ? (~quo + 1'b1) : quo;
            hi_res = neg_a ? (~rem + 1'b1) : rem;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - E-stage multiply/divide controller owning HI/LO and the D-stage stall
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       md_op_E,
   input  logic [WIDTH-1:0] src_a_E,
   input  logic [WIDTH-1:0] src_b_E,
   input  logic             md_use_D,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             start,
   output logic             busy,
   output logic             md_stall
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_t        state;
   md_state_t        state_next;
   logic [CNT_W-1:0] counter;
   logic [WIDTH-1:0] hi_res;
   logic [WIDTH-1:0] lo_res;
   logic             dz_res;
   logic [WIDTH-1:0] calc_hi;
   logic [WIDTH-1:0] calc_lo;
   logic             calc_dz;
   logic             last_cycle;

   mdu_calc #(.WIDTH(WIDTH)) u_calc (
      .op       (md_op_E),
      .a        (src_a_E),
      .b        (src_b_E),
      .hi_res   (calc_hi),
      .lo_res   (calc_lo),
      .div_zero (calc_dz)
   );

   assign last_cycle = (state == MD_BUSY) && (counter == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= MD_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         MD_IDLE: if (is_md_arith(md_op_E)) state_next = MD_BUSY;
         MD_BUSY: if (last_cycle)           state_next = MD_IDLE;
         default: state_next = MD_IDLE;
      endcase
   end

   always_comb begin
      start    = (state == MD_IDLE) && is_md_arith(md_op_E);
      busy     = (state == MD_BUSY);
      md_stall = md_use_D && (start || busy);
   end

   // Shadow result is latched at start and only copied to HI/LO on the final busy edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         counter <= '0;
         hi_res  <= '0;
         lo_res  <= '0;
         dz_res  <= 1'b0;
         hi_out  <= '0;
         lo_out  <= '0;
      end else if (state == MD_IDLE) begin
         if (start) begin
            hi_res  <= calc_hi;
            lo_res  <= calc_lo;
            dz_res  <= calc_dz;
            counter <= is_md_div(md_op_E) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         end else if (md_op_E == MD_MTHI) begin
            hi_out <= src_a_E;
         end else if (md_op_E == MD_MTLO) begin
            lo_out <= src_a_E;
         end
      end else begin
         counter <= counter - 1'b1;
         if (last_cycle && !dz_res) begin
            hi_out <= hi_res;
            lo_out <= lo_res;
         end
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - randomized self-checking bench for mdu_ctrl against an arithmetic model
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  md_op_E = 3'd0;
   logic [31:0] src_a_E = '0;
   logic [31:0] src_b_E = '0;
   logic        md_use_D = 1'b0;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        start;
   logic        busy;
   logic        md_stall;

   int n_checks = 0;
   int n_errs   = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   always #5 clk = ~clk;

   mdu_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .md_op_E  (md_op_E),
      .src_a_E  (src_a_E),
      .src_b_E  (src_b_E),
      .md_use_D (md_use_D),
      .hi_out   (hi_out),
      .lo_out   (lo_out),
      .start    (start),
      .busy     (busy),
      .md_stall (md_stall)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // inject: -1 quiet, 0 random ops every busy cycle, k>0 a MULT on busy cycle k
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input int inject);
      logic        arith;
      int          cyc;
      logic [31:0] nh;
      logic [31:0] nl;
      logic [63:0] p;
      longint      sa;
      longint      sb;
      longint unsigned ua;
      longint unsigned ub;
      arith = (op >= 3'd1) && (op <= 3'd4);
      cyc   = (op == 3'd1 || op == 3'd2) ? 5 : 10;
      nh = exp_hi;
      nl = exp_lo;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (op)
         3'd1: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; end
         3'd2: begin p = ua * ub; nh = p[63:32]; nl = p[31:0]; end
         3'd3: if (b != 0) begin nl = 32'(sa / sb); nh = 32'(sa % sb); end
         3'd4: if (b != 0) begin nl = 32'(ua / ub); nh = 32'(ua % ub); end
         3'd5: nh = a;
         3'd6: nl = a;
         default: ;
      endcase

      md_op_E  = op;
      src_a_E  = a;
      src_b_E  = b;
      md_use_D = use_d;
      #1;
      check("start", {31'b0, start}, {31'b0, arith});
      check("stall_at_start", {31'b0, md_stall}, {31'b0, use_d & arith});
      next_cycle();
      md_op_E = 3'd0;

      if (arith) begin
         for (int k = 1; k <= cyc; k++) begin
            logic u;
            u = (inject == 0) ? 1'($urandom) : use_d;
            md_use_D = u;
            if (inject == 0) begin
               md_op_E = 3'($urandom);
               src_a_E = $urandom;
               src_b_E = $urandom;
            end else if (inject == k) begin
               md_op_E = 3'd1;
               src_a_E = 32'h0000_1234;
               src_b_E = 32'h0000_5678;
            end else begin
               md_op_E = 3'd0;
            end
            #1;
            check("busy_run", {31'b0, busy}, 32'd1);
            check("no_start_busy", {31'b0, start}, 32'd0);
            check("stall_busy", {31'b0, md_stall}, {31'b0, u});
            check("hi_hold", hi_out, exp_hi);
            check("lo_hold", lo_out, exp_lo);
            next_cycle();
         end
      end

      md_op_E  = 3'd0;
      md_use_D = use_d;
      #1;
      check("busy_done", {31'b0, busy}, 32'd0);
      check("stall_done", {31'b0, md_stall}, 32'd0);
      check("hi_result", hi_out, nh);
      check("lo_result", lo_out, nl);
      exp_hi = nh;
      exp_lo = nl;
   endtask

   initial begin
      reset = 1'b0;
      next_cycle();
      next_cycle();
      reset = 1'b1;
      #1;
      check("rst_hi", hi_out, 32'h0);
      check("rst_lo", lo_out, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_stall", {31'b0, md_stall}, 32'd0);

      do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, -1);
      check("mult_hi_const", hi_out, 32'hFFFF_FFFF);
      check("mult_lo_const", lo_out, 32'hFFFF_FFFA);
      do_op(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, -1);
      check("multu_hi_const", hi_out, 32'h0000_0002);
      check("multu_lo_const", lo_out, 32'hFFFF_FFFA);
      do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, -1);
      check("div_hi_const", hi_out, 32'hFFFF_FFFF);
      check("div_lo_const", lo_out, 32'hFFFF_FFFD);
      do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
      check("div_ovf_hi", hi_out, 32'h0);
      check("div_ovf_lo", lo_out, 32'h8000_0000);

      do_op(3'd5, 32'h0000_0011, 32'h0, 1'b0, -1);
      do_op(3'd6, 32'h0000_0022, 32'h0, 1'b0, -1);
      do_op(3'd4, 32'd7, 32'd0, 1'b1, -1);
      check("divz_hi_const", hi_out, 32'h11);
      check("divz_lo_const", lo_out, 32'h22);

      do_op(3'd5, 32'hDEAD_BEEF, 32'h0, 1'b1, -1);
      do_op(3'd6, 32'h1234_5678, 32'h0, 1'b1, -1);
      check("mthi_const", hi_out, 32'hDEAD_BEEF);
      check("mtlo_const", lo_out, 32'h1234_5678);

      do_op(3'd1, 32'h0000_0100, 32'h0000_0200, 1'b1, 3);
      do_op(3'd2, 32'h0000_0003, 32'h0000_0005, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         do_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 1'($urandom), $urandom_range(0, 1) - 1);
      end

      do_op(3'd1, 32'h0000_0007, 32'h0000_0009, 1'b0, -1);
      md_op_E = 3'd1;
      src_a_E = 32'hFFFF_FFFE;
      src_b_E = 32'd3;
      next_cycle();
      md_op_E = 3'd0;
      next_cycle();
      next_cycle();
      check("pre_rst_busy", {31'b0, busy}, 32'd1);
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_hi", hi_out, 32'h0);
      check("midrst_lo", lo_out, 32'h0);
      for (int k = 0; k < 8; k++) next_cycle();
      check("postrst_busy", {31'b0, busy}, 32'd0);
      check("postrst_hi", hi_out, 32'h0);
      check("postrst_lo", lo_out, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
